// File: rtl/vend_txn_controller_if.sv
// Front-end/dispenser signal bundle for the vending transaction controller.
// master drives coins, keypad and acknowledge; slave is the controller.
interface vend_txn_controller_if;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       sel_valid;
    logic [1:0] item_select;
    logic       cancel;
    logic       disp_ack;
    logic       disp_req;
    logic [1:0] disp_item;
    logic       change_valid;
    logic [3:0] change_amt;
    logic [3:0] credit;
    logic       coin_reject;
    logic       sel_reject;
    logic       busy;

    modport master (
        output coin_valid, coin_value, sel_valid, item_select, cancel, disp_ack,
        input  disp_req, disp_item, change_valid, change_amt, credit,
               coin_reject, sel_reject, busy
    );

    modport slave (
        input  coin_valid, coin_value, sel_valid, item_select, cancel, disp_ack,
        output disp_req, disp_item, change_valid, change_amt, credit,
               coin_reject, sel_reject, busy
    );
endinterface

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: accumulates coin credit, validates priced
// selections, handshakes with the dispenser and pays out change or refunds.
module vend_txn_controller #(
    parameter int unsigned PRICE0  = 5,
    parameter int unsigned PRICE1  = 7,
    parameter int unsigned PRICE2  = 10,
    parameter int unsigned PRICE3  = 12,
    parameter int unsigned TIMEOUT = 100
) (
    input logic                  clk,
    input logic                  reset,
    vend_txn_controller_if.slave bus
);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      credit_q, credit_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            disp_req_q, disp_req_d;
    logic [1:0]      disp_item_q, disp_item_d;
    logic            change_valid_q, change_valid_d;
    logic [3:0]      change_amt_q, change_amt_d;
    logic            coin_reject_q, coin_reject_d;
    logic            sel_reject_q, sel_reject_d;
    logic            busy_q, busy_d;

    logic [3:0]      price;
    logic [4:0]      coin_sum;
    logic            coin_fits;
    logic            refund;

    always_comb begin
        unique case (bus.item_select)
            2'd0:    price = 4'(PRICE0);
            2'd1:    price = 4'(PRICE1);
            2'd2:    price = 4'(PRICE2);
            default: price = 4'(PRICE3);
        endcase
    end

    assign coin_sum  = {1'b0, credit_q} + {1'b0, bus.coin_value};
    assign coin_fits = bus.coin_valid && (coin_sum <= 5'd15);

    // Timeout counter defaults to clear; only an idle CREDIT cycle advances it.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        tmo_d          = '0;
        disp_req_d     = disp_req_q;
        disp_item_d    = disp_item_q;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        coin_reject_d  = bus.coin_valid;
        sel_reject_d   = 1'b0;
        refund         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.sel_valid) begin
                    sel_reject_d = 1'b1;
                end else if (coin_fits && !bus.cancel) begin
                    coin_reject_d = 1'b0;
                    credit_d      = coin_sum[3:0];
                    if (bus.coin_value != '0) state_d = CREDIT;
                end
            end
            CREDIT: begin
                if (bus.cancel) begin
                    refund = 1'b1;
                end else if (bus.sel_valid) begin
                    if (credit_q >= price) begin
                        credit_d    = credit_q - price;
                        disp_item_d = bus.item_select;
                        disp_req_d  = 1'b1;
                        state_d     = DISPENSE;
                    end else begin
                        sel_reject_d = 1'b1;
                    end
                end else if (coin_fits) begin
                    coin_reject_d = 1'b0;
                    credit_d      = coin_sum[3:0];
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    refund = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DISPENSE: begin
                sel_reject_d = bus.sel_valid;
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    if (credit_q != '0) refund = 1'b1;
                    else                state_d = IDLE;
                end
            end
            CHANGE: begin
                sel_reject_d = bus.sel_valid;
                state_d      = IDLE;
            end
        endcase

        if (refund) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
            credit_d       = '0;
        end

        busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            tmo_q          <= '0;
            disp_req_q     <= 1'b0;
            disp_item_q    <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            sel_reject_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            tmo_q          <= tmo_d;
            disp_req_q     <= disp_req_d;
            disp_item_q    <= disp_item_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            sel_reject_q   <= sel_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.disp_req     = disp_req_q;
    assign bus.disp_item    = disp_item_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_reject   = sel_reject_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the vending rules.
module tb_vend_txn_controller;
    localparam int unsigned TIMEOUT = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_txn_controller_if bus();

    vend_txn_controller #(
        .PRICE0(5), .PRICE1(7), .PRICE2(10), .PRICE3(12), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int price_tbl[4] = '{5, 7, 10, 12};

    int n_checks = 0;
    int n_errors = 0;

    // Model: customer session view (money held, item owed, refund strobe).
    int m_credit;
    bit m_session;
    int m_idle;
    int e_disp_req, e_disp_item, e_change_valid, e_change_amt;
    int e_coin_reject, e_sel_reject, e_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_session = 0; m_idle = 0;
        e_disp_req = 0; e_disp_item = 0; e_change_valid = 0; e_change_amt = 0;
        e_coin_reject = 0; e_sel_reject = 0; e_busy = 0;
    endtask

    task automatic model_step();
        bit cv = bus.coin_valid;
        int val = int'(bus.coin_value);
        bit sv = bus.sel_valid;
        int it = int'(bus.item_select);
        bit cn = bus.cancel;
        bit ak = bus.disp_ack;
        int coin_rej = cv;
        int sel_rej = 0;
        int chg_v = 0;
        int chg_a = 0;
        bit give_back = 0;

        if (e_change_valid != 0) begin
            sel_rej = sv;
        end else if (e_disp_req != 0) begin
            sel_rej = sv;
            if (ak) begin
                e_disp_req = 0;
                if (m_credit > 0) give_back = 1;
            end
        end else if (!m_session) begin
            if (sv) sel_rej = 1;
            else if (cv && !cn) begin
                coin_rej = 0;
                m_credit += val;
                if (val > 0) begin m_session = 1; m_idle = 0; end
            end
        end else begin
            if (cn) give_back = 1;
            else if (sv) begin
                m_idle = 0;
                if (m_credit >= price_tbl[it]) begin
                    m_credit -= price_tbl[it];
                    e_disp_req = 1;
                    e_disp_item = it;
                    m_session = 0;
                end else sel_rej = 1;
            end else if (cv && (m_credit + val <= 15)) begin
                coin_rej = 0;
                m_credit += val;
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) give_back = 1;
            end
        end

        if (give_back) begin
            chg_v = 1; chg_a = m_credit; m_credit = 0; m_session = 0;
        end
        e_change_valid = chg_v;
        e_change_amt = chg_a;
        e_coin_reject = coin_rej;
        e_sel_reject = sel_rej;
        e_busy = ((e_disp_req != 0) || (chg_v != 0)) ? 1 : 0;
    endtask

    task automatic compare_all();
        check_eq("disp_req", 32'(bus.disp_req), e_disp_req);
        check_eq("disp_item", 32'(bus.disp_item), e_disp_item);
        check_eq("change_valid", 32'(bus.change_valid), e_change_valid);
        check_eq("change_amt", 32'(bus.change_amt), e_change_amt);
        check_eq("credit", 32'(bus.credit), m_credit);
        check_eq("coin_reject", 32'(bus.coin_reject), e_coin_reject);
        check_eq("sel_reject", 32'(bus.sel_reject), e_sel_reject);
        check_eq("busy", 32'(bus.busy), e_busy);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit cv, input int val, input bit sv, input int it,
                         input bit cn, input bit ak);
        bus.coin_valid  = cv;
        bus.coin_value  = 4'(val);
        bus.sel_valid   = sv;
        bus.item_select = 2'(it);
        bus.cancel      = cn;
        bus.disp_ack    = ak;
        step();
    endtask

    task automatic quiet(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        bus.coin_valid = 0; bus.coin_value = '0; bus.sel_valid = 0;
        bus.item_select = '0; bus.cancel = 0; bus.disp_ack = 0;
        model_reset();
        #12;
        compare_all();
        reset = 1'b1;

        // exact payment
        drive(1, 5, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        quiet(2);
        drive(0, 0, 0, 0, 0, 1);
        quiet(2);

        // overpayment with change
        drive(1, 5, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        quiet(1);
        drive(0, 0, 0, 0, 0, 1);
        quiet(2);

        // insufficient credit, overflow coin, then exact
        drive(1, 8, 0, 0, 0, 0);
        drive(0, 0, 1, 2, 0, 0);
        drive(1, 10, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        quiet(2);

        // cancel, then timeout refund
        drive(1, 7, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        quiet(1);
        drive(1, 4, 0, 0, 0, 0);
        quiet(TIMEOUT + 2);

        // simultaneous events
        drive(1, 12, 0, 0, 0, 0);
        drive(1, 1, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        quiet(1);
        drive(1, 5, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        quiet(2);

        // asynchronous reset while dispensing with credit left over
        drive(1, 10, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        quiet(1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_disp_req", 32'(bus.disp_req), 0);
        check_eq("rst_credit", 32'(bus.credit), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        model_reset();
        #3;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 0, 0);
        quiet(1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                quiet(TIMEOUT + 3);
            end else begin
                drive($urandom_range(0, 99) < 30,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 6),
                      $urandom_range(0, 99) < 12,
                      $urandom_range(0, 3),
                      $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 35);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
